// File: rtl/relu_activation_stream.sv
// Streaming fixed-point activation layer: ReLU / leaky / clipped / bypass over LANES-wide beats,
// two-stage valid/ready pipeline with per-frame mode latching and a completed-frame counter.
module relu_activation_stream #(
    parameter int WIDTH       = 10,
    parameter int NFRAC       = 5,
    parameter int SIZE        = 32,
    parameter int LANES       = 8,
    parameter int LEAKY_SHIFT = 3,
    parameter int CLIP_MAX    = 6 << NFRAC,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data [LANES],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data [LANES],
    output logic                    out_last,
    output logic [CNT_W-1:0]        frame_count
);
    localparam int BEATS  = SIZE / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] MODE_RELU  = 2'd0;
    localparam logic [1:0] MODE_LEAKY = 2'd1;
    localparam logic [1:0] MODE_CLIP  = 2'd2;

    localparam logic signed [WIDTH-1:0] CLIP_CODE = WIDTH'(CLIP_MAX);

    generate
        if (SIZE % LANES != 0) begin : g_bad_size
            $error("relu_activation_stream: SIZE must be a multiple of LANES");
        end
        if (CLIP_MAX <= 0 || CLIP_MAX > (2 ** (WIDTH - 1)) - 1) begin : g_bad_clip
            $error("relu_activation_stream: CLIP_MAX out of range");
        end
    endgenerate

    function automatic logic signed [WIDTH-1:0] activate(
        input logic signed [WIDTH-1:0] x,
        input logic [1:0]              m
    );
        logic signed [WIDTH-1:0] y;
        y = x;
        case (m)
            MODE_RELU:  y = x[WIDTH-1] ? '0 : x;
            MODE_LEAKY: y = x[WIDTH-1] ? (x >>> LEAKY_SHIFT) : x;
            MODE_CLIP:  y = x[WIDTH-1] ? '0 : ((x > CLIP_CODE) ? CLIP_CODE : x);
            default:    y = x;
        endcase
        return y;
    endfunction

    logic                    adv1;
    logic                    adv2;
    logic                    in_fire;
    logic                    out_fire;
    logic                    beat_last;
    logic [1:0]              beat_mode;
    logic [BEAT_W-1:0]       in_beat_cnt;
    logic [1:0]              frame_mode_reg;
    logic                    s1_valid;
    logic                    s1_last;
    logic [1:0]              s1_mode;
    logic signed [WIDTH-1:0] s1_data [LANES];
    logic signed [WIDTH-1:0] act     [LANES];

    assign adv2      = !out_valid || out_ready;
    assign adv1      = !s1_valid || adv2;
    assign in_ready  = adv1;
    assign in_fire   = in_valid && adv1;
    assign out_fire  = out_valid && out_ready;
    assign beat_last = (in_beat_cnt == BEAT_W'(BEATS - 1));
    // Beat 0 takes the live mode input; the rest of the frame reuses what beat 0 saw.
    assign beat_mode = (in_beat_cnt == '0) ? mode : frame_mode_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_beat_cnt    <= '0;
            frame_mode_reg <= '0;
            s1_valid       <= 1'b0;
            s1_last        <= 1'b0;
            s1_mode        <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            frame_count    <= '0;
        end else begin
            if (in_fire) begin
                in_beat_cnt <= beat_last ? '0 : in_beat_cnt + 1'b1;
                if (in_beat_cnt == '0) begin
                    frame_mode_reg <= mode;
                end
            end
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_fire) begin
                    s1_last <= beat_last;
                    s1_mode <= beat_mode;
                end
            end
            if (adv2) begin
                out_valid <= s1_valid;
                out_last  <= s1_valid && s1_last;
            end
            if (out_fire && out_last) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign act[gi] = activate(s1_data[gi], s1_mode);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                s1_data[i]  <= '0;
                out_data[i] <= '0;
            end
        end else begin
            if (in_fire) begin
                s1_data <= in_data;
            end
            if (adv2 && s1_valid) begin
                out_data <= act;
            end
        end
    end
endmodule
